// File: rtl/ex_mem_fp_reg.sv
// EX->MEM stage: 2-entry skid buffer after alu_fp, NZVC commit register, head forwarding. Optional FP_SAT_EN saturates overflowed results at capture.
// Latency: 1 cycle input-to-output when empty; sustains 1 op/cycle with out_ready held high.
// Backpressure: in_ready is registered and drops only while both entries are occupied.
module ex_mem_fp_reg #(
   parameter int N  = 24,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_result,
   input  logic [3:0]    in_flags,
   input  logic [RW-1:0] in_rd,
   input  logic          in_we,
   input  logic          in_setf,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_result,
   output logic [RW-1:0] out_rd,
   output logic          out_we,
   output logic [3:0]    flags_q,
   output logic          fwd_valid,
   output logic [RW-1:0] fwd_rd,
   output logic [N-1:0]  fwd_result
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   typedef struct packed {
      logic [N-1:0]  result;
      logic [3:0]    flags;
      logic [RW-1:0] rd;
      logic          we;
      logic          setf;
   } entry_t;

   state_t     state_q, state_d;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   entry_t     cap_entry;
   logic [3:0] flags_d;
   logic       accept;
   logic       commit;

   // Entry as it will be stored; flags are {N,Z,V,C}.
   always_comb begin
      cap_entry.result = in_result;
      cap_entry.flags  = in_flags;
      cap_entry.rd     = in_rd;
      cap_entry.we     = in_we;
      cap_entry.setf   = in_setf;
`ifdef FP_SAT_EN
      if (in_flags[1]) begin
         cap_entry.result[14:0] = 15'h7FFF;
         cap_entry.flags[2]     = 1'b0;
      end
`else
`endif
   end

   assign in_ready  = (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign commit    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      flags_d = flags_q;
      // Flush wins over any same-cycle commit or accept.
      if (flush) begin
         state_d = EMPTY;
      end else begin
         if (commit && head_q.setf) flags_d = head_q.flags;
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  head_d  = cap_entry;
               end
            end
            ONE: begin
               case ({accept, commit})
                  2'b10: begin
                     state_d = TWO;
                     skid_d  = cap_entry;
                  end
                  2'b01: state_d = EMPTY;
                  2'b11: head_d = cap_entry;
                  default: ;
               endcase
            end
            TWO: begin
               if (commit) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         flags_q <= flags_d;
      end
   end

   assign out_result = head_q.result;
   assign out_rd     = head_q.rd;
   assign out_we     = head_q.we & out_valid;
   assign fwd_valid  = out_valid & head_q.we;
   assign fwd_rd     = head_q.rd;
   assign fwd_result = head_q.result;

endmodule

// File: tb/tb_ex_mem_fp_reg.sv
// Directed bench for ex_mem_fp_reg: single op, backpressure, flag commit, flush, async reset, saturation.
module tb_ex_mem_fp_reg;
   localparam int N  = 24;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_result;
   logic [3:0]    in_flags;
   logic [RW-1:0] in_rd;
   logic          in_we;
   logic          in_setf;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_result;
   logic [RW-1:0] out_rd;
   logic          out_we;
   logic [3:0]    flags_q;
   logic          fwd_valid;
   logic [RW-1:0] fwd_rd;
   logic [N-1:0]  fwd_result;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ex_mem_fp_reg #(.N(N), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_we(out_we), .flags_q(flags_q),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N-1:0] res, input logic [3:0] fl,
                        input logic [RW-1:0] rd, input logic we, input logic setf);
      in_valid  = v;
      in_result = res;
      in_flags  = fl;
      in_rd     = rd;
      in_we     = we;
      in_setf   = setf;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_flags",     32'(flags_q),   32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
      rst_n = 1'b1;

      // Single op
      out_ready = 1'b1;
      drive(1'b1, 24'h000180, 4'b0000, 5'd3, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_out_result", 32'(out_result), 32'h180);
      chk("single_out_we", 32'(out_we), 32'd1);
      chk("single_fwd_valid", 32'(fwd_valid), 32'd1);
      chk("single_fwd_rd", 32'(fwd_rd), 32'd3);
      chk("single_fwd_result", 32'(fwd_result), 32'h180);
      tick();
      chk("single_drained", 32'(out_valid), 32'd0);
      chk("single_flags", 32'(flags_q), 32'd0);

      // Backpressure: A, B fill the buffer, C is held off
      out_ready = 1'b0;
      drive(1'b1, 24'h000001, 4'b0000, 5'd1, 1'b1, 1'b0);
      tick();
      chk("bp_one_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 24'h000002, 4'b0000, 5'd2, 1'b1, 1'b0);
      tick();
      chk("bp_two_in_ready", 32'(in_ready), 32'd0);
      chk("bp_two_head", 32'(out_result), 32'h1);
      drive(1'b1, 24'h000003, 4'b0000, 5'd3, 1'b1, 1'b0);
      tick();
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_head", 32'(out_result), 32'h1);
      chk("bp_hold_rd", 32'(out_rd), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_b_head", 32'(out_result), 32'h2);
      chk("bp_b_in_ready", 32'(in_ready), 32'd1);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("bp_c_head", 32'(out_result), 32'h3);
      chk("bp_c_rd", 32'(out_rd), 32'd3);
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Flags update only on commit of a setf op
      out_ready = 1'b0;
      drive(1'b1, 24'h000010, 4'b1000, 5'd4, 1'b1, 1'b1);
      tick();
      drive(1'b1, 24'h000020, 4'b0100, 5'd5, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("fl_stall_flags0", 32'(flags_q), 32'd0);
      tick();
      chk("fl_stall_flags1", 32'(flags_q), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("fl_op1_flags", 32'(flags_q), 32'b1000);
      chk("fl_op2_head", 32'(out_result), 32'h20);
      tick();
      chk("fl_op2_flags", 32'(flags_q), 32'b1000);
      chk("fl_drained", 32'(out_valid), 32'd0);

      // Flush with a full buffer and a same-edge commit
      out_ready = 1'b0;
      drive(1'b1, 24'h000030, 4'b0001, 5'd6, 1'b1, 1'b1);
      tick();
      drive(1'b1, 24'h000040, 4'b0001, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("fsh_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fsh_out_valid", 32'(out_valid), 32'd0);
      chk("fsh_flags", 32'(flags_q), 32'b1000);
      chk("fsh_in_ready", 32'(in_ready), 32'd1);
      chk("fsh_fwd_valid", 32'(fwd_valid), 32'd0);

      // Async reset while full
      out_ready = 1'b0;
      drive(1'b1, 24'h000050, 4'b0010, 5'd8, 1'b1, 1'b1);
      tick();
      drive(1'b1, 24'h000060, 4'b0010, 5'd9, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("ar_pre_full", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_flags", 32'(flags_q), 32'd0);
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 24'h000055, 4'b0000, 5'd7, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
      chk("ar_new_valid", 32'(out_valid), 32'd1);
      chk("ar_new_result", 32'(out_result), 32'h55);
      chk("ar_new_rd", 32'(out_rd), 32'd7);
      tick();

      // Overflowed result: saturated only when FP_SAT_EN is defined
      drive(1'b1, 24'hAB8123, 4'b0110, 5'd2, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
`ifdef FP_SAT_EN
      chk("sat_result", 32'(out_result), 32'hABFFFF);
`else
      chk("sat_result", 32'(out_result), 32'hAB8123);
`endif
      tick();
`ifdef FP_SAT_EN
      chk("sat_flags", 32'(flags_q), 32'b0010);
`else
      chk("sat_flags", 32'(flags_q), 32'b0110);
`endif
      chk("sat_drained", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
